// File: rtl/udp_pkg.sv
// udp_pkg: shared FSM encoding, UDP header length and keep-mask helper
// for the UDP payload forwarding path.
package udp_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP, ST_FLUSH} state_t;
   localparam int UDP_HDR_LEN = 8;
   function automatic logic [15:0] keep_mask(input logic [4:0] cnt);
      return (cnt >= 5'd16) ? 16'hffff : (16'd1 << cnt) - 16'd1;
   endfunction
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry skid buffer with registered outputs and a
// registered s_ready, sustaining one transfer per cycle in both directions.
module stream_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] s_data,
   input  logic         s_valid,
   output logic         s_ready,
   output logic [W-1:0] m_data,
   output logic         m_valid,
   input  logic         m_ready
);
   logic [W-1:0] r_out, r_sk;
   logic         r_out_v, r_sk_v;
   logic         w_in;
   assign w_in    = s_valid && s_ready;
   assign s_ready = !r_sk_v;
   assign m_data  = r_out;
   assign m_valid = r_out_v;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out   <= '0;
         r_sk    <= '0;
         r_out_v <= 1'b0;
         r_sk_v  <= 1'b0;
      end else if (!r_out_v || m_ready) begin
         r_out_v <= r_sk_v || w_in;
         r_sk_v  <= 1'b0;
         if (r_sk_v)
            r_out <= r_sk;
         else if (w_in)
            r_out <= s_data;
      end else if (w_in) begin
         // output stalled: park the incoming word in the skid slot
         r_sk   <= s_data;
         r_sk_v <= 1'b1;
      end
   end
endmodule

// File: rtl/payload_stream_forwarder.sv
// payload_stream_forwarder: trims a beat stream to udp_length-HDR_LEN payload
// bytes with exact keep/last, drops or flushes packets, and flags length errors.
module payload_stream_forwarder
   import udp_pkg::*;
#(
   parameter int BYTES   = 4,
   parameter int LEN_W   = 16,
   parameter int HDR_LEN = UDP_HDR_LEN
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [8*BYTES-1:0] s_data,
   input  logic [BYTES-1:0]   s_keep,
   input  logic               s_valid,
   input  logic               s_last,
   output logic               s_ready,
   input  logic               hdr_done,
   input  logic [LEN_W-1:0]   udp_length,
   input  logic               drop_en,
   output logic [8*BYTES-1:0] m_data,
   output logic [BYTES-1:0]   m_keep,
   output logic               m_valid,
   output logic               m_last,
   input  logic               m_ready,
   output logic               len_short,
   output logic               len_long,
   output logic               pkt_done
);
   localparam int TW = $clog2(BYTES) + 1;
   localparam int W  = 9 * BYTES + 1;
   localparam logic [LEN_W-1:0] HL = LEN_W'(HDR_LEN);
   state_t             r_state, w_state_nx;
   logic [LEN_W-1:0]   r_rem, w_rem_nx, w_rem_sub;
   logic [TW-1:0]      w_n, w_take;
   logic [15:0]        w_mask;
   logic [BYTES-1:0]   w_keep;
   logic [W-1:0]       w_m_word;
   logic               w_acc, w_fwd_valid, w_fwd_ready;
   logic               w_last, w_short, w_long, w_done;
   logic               r_short, r_long, r_done;
   always_comb begin
      w_n = '0;
      for (int i = 0; i < BYTES; i++)
         w_n = w_n + TW'(s_keep[i]);
   end
   assign w_take      = (LEN_W'(w_n) <= r_rem) ? w_n : TW'(r_rem);
   assign w_rem_sub   = r_rem - LEN_W'(w_take);
   assign w_mask      = keep_mask(5'(w_take));
   assign w_keep      = s_keep & w_mask[BYTES-1:0];
   assign s_ready     = (r_state == ST_FWD) ? w_fwd_ready : (r_state == ST_DROP || r_state == ST_FLUSH);
   assign w_acc       = s_valid && s_ready;
   // empty beats never enter the skid, even when they carry s_last
   assign w_fwd_valid = s_valid && (r_state == ST_FWD) && (w_n != '0);
   always_comb begin
      w_state_nx = r_state;
      w_rem_nx   = r_rem;
      w_last     = 1'b0;
      w_short    = 1'b0;
      w_long     = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         ST_IDLE: if (hdr_done) begin
            w_rem_nx   = (udp_length > HL) ? udp_length - HL : '0;
            w_short    = udp_length < HL;
            w_state_nx = drop_en ? ST_DROP : (udp_length > HL) ? ST_FWD : ST_FLUSH;
         end
         ST_FWD: if (w_acc) begin
            if (w_n == '0) begin
               w_short    = s_last;
               w_done     = s_last;
               w_state_nx = s_last ? ST_IDLE : ST_FWD;
            end else begin
               w_rem_nx = w_rem_sub;
               w_last   = s_last || (w_rem_sub == '0);
               if (w_rem_sub == '0) begin
                  w_long     = !s_last || (w_n != w_take);
                  w_done     = s_last;
                  w_state_nx = s_last ? ST_IDLE : ST_FLUSH;
               end else if (s_last) begin
                  w_short    = 1'b1;
                  w_done     = 1'b1;
                  w_state_nx = ST_IDLE;
               end
            end
         end
         default: if (w_acc && s_last) begin
            w_done     = 1'b1;
            w_state_nx = ST_IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_rem   <= '0;
         r_short <= 1'b0;
         r_long  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_rem   <= w_rem_nx;
         r_short <= w_short;
         r_long  <= w_long;
         r_done  <= w_done;
      end
   end
   assign len_short = r_short;
   assign len_long  = r_long;
   assign pkt_done  = r_done;
   stream_skid_buf #(.W(W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  ({w_last, w_keep, s_data}),
      .s_valid (w_fwd_valid),
      .s_ready (w_fwd_ready),
      .m_data  (w_m_word),
      .m_valid (m_valid),
      .m_ready (m_ready)
   );
   assign {m_last, m_keep, m_data} = w_m_word;
endmodule

// File: tb/tb_payload_stream_forwarder.sv
// tb_payload_stream_forwarder: directed and random packets checked against a
// byte-count reference model of the payload trimming rules.
module tb_payload_stream_forwarder;
   typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] s_data = '0, m_data;
   logic [3:0]  s_keep = '0, m_keep;
   logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
   logic        hdr_done = 1'b0, drop_en = 1'b0;
   logic [15:0] udp_length = '0;
   logic        m_valid, m_last, m_ready;
   logic        len_short, len_long, pkt_done;
   int          n_tests = 0, n_fail = 0;
   int          n_short = 0, n_long = 0, n_done = 0, n_mv = 0;
   int          hold = 0, cnt[16], stall[16];
   bit          ready_rand = 0, prev_stall = 0;
   logic [37:0] prev_word;
   beat_t       exp_q[$], mon_e;
   logic [4:0]  obs_q[$];

   payload_stream_forwarder #(.BYTES(4), .LEN_W(16), .HDR_LEN(8)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready), .hdr_done(hdr_done), .udp_length(udp_length),
      .drop_en(drop_en), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid),
      .m_last(m_last), .m_ready(m_ready), .len_short(len_short), .len_long(len_long),
      .pkt_done(pkt_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] kmask(input int c);
      return 4'((1 << c) - 1);
   endfunction

   function automatic logic [31:0] bmask(input logic [3:0] k);
      for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{k[i]}};
   endfunction

   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (hold > 0) begin
            m_ready = 1'b0;
            hold--;
         end else m_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) prev_stall = 0;
      else begin
         if (prev_stall) chk("hold_stable", {m_valid, m_last, m_keep, m_data}, prev_word);
         prev_stall = m_valid && !m_ready;
         prev_word  = {m_valid, m_last, m_keep, m_data};
         n_mv    += int'(m_valid);
         n_short += int'(len_short);
         n_long  += int'(len_long);
         n_done  += int'(pkt_done);
         if (m_valid && m_ready) begin
            obs_q.push_back({m_last, m_keep});
            if (exp_q.size() == 0) chk("unexpected_beat", {m_last, m_keep}, 0);
            else begin
               mon_e = exp_q.pop_front();
               chk("m_keep", m_keep, mon_e.k);
               chk("m_last", m_last, mon_e.l);
               chk("m_data", m_data & bmask(mon_e.k), mon_e.d & bmask(mon_e.k));
            end
         end
      end
   end

   task automatic put_beat(input logic [31:0] d, input logic [3:0] k, input bit l, output int st);
      bit acc = 0;
      s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; st = 0;
      while (!acc && st < 300) begin
         @(negedge clk); acc = s_ready;
         @(posedge clk); #1;
         if (!acc) st++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_hdr(input int len, input bit drop);
      udp_length = 16'(len); drop_en = drop; hdr_done = 1'b1;
      @(posedge clk); #1;
      hdr_done = 1'b0; drop_en = 1'b0;
   endtask

   // model: beat i yields min(count, payload bytes still owed); packet ends when
   // the payload is complete or the frame ends, whichever comes first
   task automatic send_pkt(input int len, input bit drop, input int nb, input bit gaps);
      logic [31:0] d[16];
      int p, cum, o, k, b_s, b_l, b_d;
      bit sh, lg, last;
      for (int i = 0; i < nb; i++) d[i] = $urandom;
      p = (len > 8) ? len - 8 : 0;
      sh = len < 8; lg = 0; cum = 0;
      if (!drop && p > 0)
         for (int i = 0; i < nb; i++) begin
            o = (cnt[i] < p - cum) ? cnt[i] : p - cum;
            last = (i == nb - 1);
            if (o > 0) begin
               exp_q.push_back('{d[i], kmask(o), (cum + o == p) || last});
               cum += o;
            end
            if (cum == p) begin lg = !last || cnt[i] > o; break; end
            if (last) begin sh = 1; break; end
         end
      b_s = n_short; b_l = n_long; b_d = n_done;
      send_hdr(len, drop);
      for (int i = 0; i < nb; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         put_beat(d[i], kmask(cnt[i]), i == nb - 1, stall[i]);
      end
      k = 0;
      while ((n_done == b_d || exp_q.size() != 0) && k < 400) begin
         @(posedge clk); #1; k++;
      end
      chk("pkt_done", n_done - b_d, 1);
      chk("len_short", n_short - b_s, sh);
      chk("len_long", n_long - b_l, lg);
      chk("drained", exp_q.size(), 0);
   endtask

   initial begin
      int b, st;
      #23;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_keep", m_keep, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_pulses", {len_short, len_long, pkt_done}, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("idle_s_ready", s_ready, 0);
      // 10-byte payload over three full beats
      obs_q.delete();
      cnt[0] = 4; cnt[1] = 4; cnt[2] = 4;
      send_pkt(18, 0, 3, 0);
      chk("t1_beats", obs_q.size(), 3);
      if (obs_q.size() == 3) begin
         chk("t1_b0", obs_q[0], 5'h0f);
         chk("t1_b1", obs_q[1], 5'h0f);
         chk("t1_b2", obs_q[2], 5'h13);
      end
      // backpressure mid-packet
      hold = 5;
      cnt[0] = 4; cnt[1] = 4;
      send_pkt(16, 0, 2, 0);
      hold = 10;
      for (int i = 0; i < 5; i++) cnt[i] = 4;
      send_pkt(28, 0, 5, 0);
      chk("skid_b0_nostall", stall[0], 0);
      chk("skid_b1_nostall", stall[1], 0);
      chk("skid_full_stall", stall[2] > 0, 1);
      // frame shorter than payload
      cnt[0] = 4; cnt[1] = 4;
      send_pkt(28, 0, 2, 0);
      // dropped packet
      b = n_mv;
      for (int i = 0; i < 5; i++) cnt[i] = 4;
      send_pkt(30, 1, 5, 0);
      chk("drop_no_valid", n_mv - b, 0);
      for (int i = 0; i < 5; i++) chk("drop_s_ready", stall[i], 0);
      // zero-length and undersized udp_length
      b = n_mv;
      cnt[0] = 4; cnt[1] = 2;
      send_pkt(8, 0, 2, 0);
      send_pkt(4, 0, 2, 0);
      chk("flush_no_valid", n_mv - b, 0);
      // reset while output is stalled
      hold = 40;
      @(posedge clk); #1;
      send_hdr(28, 0);
      put_beat(32'h11223344, 4'hf, 0, st);
      put_beat(32'h55667788, 4'hf, 0, st);
      @(posedge clk); #1;
      chk("pre_rst_valid", m_valid, 1);
      rst_n = 1'b0; #1;
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_m_last", m_last, 0);
      chk("midrst_m_keep", m_keep, 0);
      chk("midrst_m_data", m_data, 0);
      chk("midrst_s_ready", s_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; hold = 0; exp_q.delete();
      @(posedge clk); #1;
      cnt[0] = 4; cnt[1] = 4; cnt[2] = 1;
      send_pkt(17, 0, 3, 0);
      // random traffic
      ready_rand = 1;
      for (int t = 0; t < 60; t++) begin
         int nb;
         nb = $urandom_range(1, 8);
         for (int i = 0; i < nb; i++)
            cnt[i] = (i == nb - 1) ? $urandom_range(0, 4) : ($urandom_range(0, 9) == 0 ? 0 : 4);
         if ($urandom_range(0, 5) == 0) hold = $urandom_range(1, 6);
         send_pkt($urandom_range(0, 60), $urandom_range(0, 7) == 0, nb, 1);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/payload_stream_forwarder.md
Name: payload_stream_forwarder

Overview:
- Parametrised successor of the single-byte UDP payload forwarder.
- Sits after the UDP header parser. Accepts a BYTES-wide beat stream holding the payload bytes that follow the 8-byte UDP header.
- Forwards exactly udp_length-8 payload bytes with a byte-accurate keep mask and last flag, or drops the packet.
- Discards excess trailing bytes, flags length mismatches, and registers the output through a 2-entry skid buffer for full-throughput backpressure.

Parameters:
- BYTES, 4, bytes per beat (1..16, power of two).
- LEN_W, 16, width of the length field and remaining-byte counter.
- HDR_LEN, 8, UDP header bytes subtracted from udp_length.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_data  in  8*BYTES  input payload beat; byte 0 in bits [7:0]
- s_keep  in  BYTES  input byte-valid mask, contiguous from bit 0
- s_valid  in  1  input beat valid
- s_last  in  1  input end-of-frame (MAC boundary)
- s_ready  out  1  input accept
- hdr_done  in  1  one-cycle pulse: header parsed, udp_length and drop_en valid
- udp_length  in  LEN_W  UDP length field (header + payload)
- drop_en  in  1  drop this packet; sampled with hdr_done
- m_data  out  8*BYTES  output payload beat
- m_keep  out  BYTES  output byte-valid mask
- m_valid  out  1  output valid
- m_last  out  1  last payload beat
- m_ready  in  1  downstream accept
- len_short  out  1  pulse: frame ended before the payload was complete, or udp_length < HDR_LEN
- len_long  out  1  pulse: frame carried bytes beyond the payload
- pkt_done  out  1  pulse: packet fully consumed, returning to IDLE

Behaviour:
- Reset: state=IDLE, remaining=0, skid empty. All outputs 0: m_valid, m_last, m_keep, m_data, s_ready, and all pulses.
- Handshake: a transfer occurs when valid && ready. m_valid/m_data/m_keep/m_last are held stable while m_valid && !m_ready.
- Skid buffer:
  - Accepted beats appear on m_* one cycle later (latency 1).
  - Full rate with m_ready=1.
  - Forwarding-side s_ready = skid not full, i.e. fewer than 2 entries, registered.
- State IDLE:
  - s_ready=0.
  - On hdr_done, remaining <= (udp_length > HDR_LEN) ? udp_length-HDR_LEN : 0, computed at LEN_W width with no wrap.
  - If udp_length < HDR_LEN, pulse len_short.
  - Next state: drop_en -> DROP; else remaining==0 -> FLUSH; else FWD.
- State FWD:
  - Per accepted beat, n = popcount(s_keep) and take = min(n, remaining).
  - m_keep = s_keep masked to the low `take` bits.
  - remaining -= take.
  - Case remaining hits 0 and s_last=1: m_last=1, pulse pkt_done, go to IDLE. If n > take, also pulse len_long.
  - Case remaining hits 0 and s_last=0: m_last=1, pulse len_long, go to FLUSH.
  - Case s_last=1 with remaining still > 0: m_last=1, pulse len_short and pkt_done, go to IDLE.
  - A beat with s_keep=0 is consumed, not forwarded, and does not change remaining unless s_last=1. If s_last=1, it is still not forwarded: the beat is discarded, len_short and pkt_done pulse, and the state goes to IDLE. The packet then has no output beat carrying m_last=1.
- State DROP:
  - s_ready=1; all beats are discarded.
  - On the beat with s_last, pulse pkt_done and go to IDLE.
  - No length checks.
- State FLUSH:
  - s_ready=1; beats are discarded.
  - On s_last, pulse pkt_done and go to IDLE.
- hdr_done outside IDLE is ignored; the packet in flight is unaffected.
- Pulses are registered, one cycle wide, and coincide with the cycle after the triggering input accept.
- Reset mid-packet: the skid is cleared immediately, m_valid drops, and there is no partial m_last.

Decomposition:
- Package udp_pkg: state enum (IDLE, FWD, DROP, FLUSH), UDP_HDR_LEN=8, and a function for the keep mask from a count.
- Sub-module stream_skid_buf, parameter W, holding data, keep and last as one word: 2-entry registered-output skid buffer with a valid/ready pair on each side.

Test Plan:
- BYTES=4, udp_length=18 (10 B payload), 3 full beats, s_last on the 3rd -> m_keep 1111, 1111, 0011; m_last on beat 3; len_long and pkt_done pulse.
- udp_length=16, 2 beats with s_last on the 2nd, m_ready low for 3 cycles mid-packet -> no beat lost or duplicated; s_ready deasserts after 2 buffered beats; m_last on beat 2; pkt_done only.
- udp_length=28 (20 B), frame ends after 2 beats -> 2 beats out, m_last on beat 2, len_short pulse, state back to IDLE.
- drop_en=1 with hdr_done, 5-beat frame -> m_valid never asserts, s_ready=1 throughout, pkt_done on the beat with s_last.
- udp_length=8 then udp_length=4 -> no output; first packet flushed with pkt_done; second packet gives a len_short pulse at hdr_done and is flushed.
- Assert rst_n low while m_valid && !m_ready mid-packet -> all outputs 0 immediately; the next packet after reset is forwarded correctly.
